periph_bus_ctrl: RTL and testbench

Parametrised peripheral-bus controller between the CPU wishbone port and the IOC-space slaves (IOC, FDC, latches, podules, future expansions). It replaces hand-written per-slave gating and the priority read-data mux with a registered state machine. It adds per-speed-class wait states taken from the IOC cycle-type address bits, a bus timeout that returns `m_err`, a registered read-data path, and a default all-ones read for unclaimed addresses.

---
 rtl/periph_bus_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_periph_bus_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus_ctrl.sv
// Peripheral-bus controller: wishbone master port to NSLV IOC-space slaves.
// Ports: m_* master side, s_* slave side, busy = not idle. clkcpu, rst_n async low.
module periph_bus_ctrl #(
  parameter int NSLV    = 4,
  parameter int DW      = 32,
  parameter int AW      = 14,
  parameter int WS_SLOW = 15,
  parameter int WS_MED  = 7,
  parameter int WS_FAST = 3,
  parameter int TIMEOUT = 255
) (
  input  logic              clkcpu,
  input  logic              rst_n,
  input  logic              m_cyc,
  input  logic              m_stb,
  input  logic              m_we,
  input  logic [AW-1:0]     m_adr,
  input  logic [DW-1:0]     m_dat_i,
  input  logic [1:0]        m_speed,
  input  logic [NSLV-1:0]   m_slv,
  output logic              m_ack,
  output logic              m_err,
  output logic [DW-1:0]     m_dat_o,
  output logic [NSLV-1:0]   s_cyc,
  output logic [NSLV-1:0]   s_stb,
  output logic              s_we,
  output logic [AW-1:0]     s_adr,
  output logic [DW-1:0]     s_dat_o,
  input  logic [NSLV-1:0]   s_ack,
  input  logic [NSLV*DW-1:0] s_dat_i,
  output logic              busy
);

  localparam int WM01 = (WS_SLOW > WS_MED) ? WS_SLOW : WS_MED;
  localparam int WMAX = (WM01 > WS_FAST) ? WM01 : WS_FAST;
  localparam int WCW  = (WMAX < 1) ? 1 : $clog2(WMAX + 1);
  localparam int TCW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE,
    S_ERR
  } state_t;

  state_t            r_state;
  state_t            w_nxt;
  logic [NSLV-1:0]   r_sel;
  logic              r_we;
  logic [AW-1:0]     r_adr;
  logic [DW-1:0]     r_dat;
  logic [WCW-1:0]    r_wait;
  logic [TCW-1:0]    r_to;
  logic [DW-1:0]     r_rdat;
  logic              r_ack;
  logic              r_err;

  logic              w_req;
  logic [NSLV-1:0]   w_hit;
  logic [WCW-1:0]    w_ws;
  logic              w_sack;
  logic              w_to;
  logic [DW-1:0]     w_lane;

  assign w_req  = m_cyc & m_stb;
  // Isolate the lowest set bit: slave 0 wins decode ties.
  assign w_hit  = m_slv & (~m_slv + NSLV'(1));
  assign w_sack = |(s_ack & r_sel);
  assign w_to   = (r_to == TCW'(TIMEOUT));

  always_comb begin
    w_ws = '0;
    unique case (m_speed)
      2'd0: w_ws = WCW'(WS_SLOW);
      2'd1: w_ws = WCW'(WS_MED);
      2'd2: w_ws = WCW'(WS_FAST);
      2'd3: w_ws = '0;
    endcase
  end

  // r_sel is one-hot, so OR-ing the selected lanes is a plain mux.
  always_comb begin
    w_lane = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (r_sel[k]) w_lane = w_lane | s_dat_i[k*DW +: DW];
    end
  end

  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (m_slv == '0)     w_nxt = S_DONE;
          else if (w_ws != '0) w_nxt = S_WAIT;
          else                 w_nxt = S_ACCESS;
        end
      end
      S_WAIT: begin
        if (!m_cyc)                 w_nxt = S_IDLE;
        else if (r_wait <= WCW'(1)) w_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (!m_cyc)      w_nxt = S_IDLE;
        else if (w_sack) w_nxt = S_DONE;
        else if (w_to)   w_nxt = S_ERR;
      end
      S_DONE:  w_nxt = S_IDLE;
      S_ERR:   w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    s_cyc = '0;
    s_stb = '0;
    busy  = (r_state != S_IDLE);
    unique case (r_state)
      S_WAIT: s_cyc = r_sel;
      S_ACCESS: begin
        s_cyc = r_sel;
        s_stb = r_sel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      r_sel  <= '0;
      r_we   <= 1'b0;
      r_adr  <= '0;
      r_dat  <= '0;
      r_wait <= '0;
      r_to   <= '0;
      r_rdat <= '0;
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      // Completion pulses trail DONE/ERR by one edge.
      r_ack <= (r_state == S_DONE);
      r_err <= (r_state == S_ERR);
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_we   <= m_we;
            r_adr  <= m_adr;
            r_dat  <= m_dat_i;
            r_sel  <= w_hit;
            r_wait <= w_ws;
            r_to   <= '0;
            if ((m_slv == '0) && !m_we) r_rdat <= '1;
          end
        end
        S_WAIT: begin
          if (r_wait != '0) r_wait <= r_wait - 1'b1;
        end
        S_ACCESS: begin
          if (m_cyc) begin
            if (w_sack) begin
              if (!r_we) r_rdat <= w_lane;
            end else if (!w_to) begin
              r_to <= r_to + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign m_ack   = r_ack;
  assign m_err   = r_err;
  assign m_dat_o = r_rdat;
  assign s_we    = r_we;
  assign s_adr   = r_adr;
  assign s_dat_o = r_dat;

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Bench for periph_bus_ctrl: vector table plus abort/reset sequences.
// Expected completions queue up at drive time and are popped on m_ack/m_err.
module tb_periph_bus_ctrl;
  localparam int NSLV = 4;
  localparam int DW   = 32;
  localparam int AW   = 14;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
  logic [AW-1:0]     m_adr = '0;
  logic [DW-1:0]     m_dat_i = '0;
  logic [1:0]        m_speed = '0;
  logic [NSLV-1:0]   m_slv = '0;
  logic              m_ack, m_err, s_we, busy;
  logic [DW-1:0]     m_dat_o, s_dat_o;
  logic [NSLV-1:0]   s_cyc, s_stb, s_ack;
  logic [AW-1:0]     s_adr;
  logic [NSLV*DW-1:0] s_dat_i;
  logic [NSLV-1:0]   ack_en = '0, ack_force = '0;

  assign s_dat_i = {32'h3333_3333, 32'h2222_2222,
                    32'h0000_00A5, 32'h1111_0000};
  assign s_ack = (s_stb & ack_en) | ack_force;

  always #5 clk = ~clk;

  periph_bus_ctrl #(.TIMEOUT(8)) dut (
    .clkcpu(clk), .rst_n(rst_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_adr(m_adr), .m_dat_i(m_dat_i), .m_speed(m_speed),
    .m_slv(m_slv), .m_ack(m_ack), .m_err(m_err),
    .m_dat_o(m_dat_o), .s_cyc(s_cyc), .s_stb(s_stb),
    .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o),
    .s_ack(s_ack), .s_dat_i(s_dat_i), .busy(busy)
  );

  typedef struct {
    logic [1:0]  sp;
    logic [3:0]  slv;
    logic        we;
    logic [13:0] adr;
    logic [31:0] dat;
    logic [3:0]  aen;
    logic [3:0]  afo;
    logic        err;
    int          lat;
    logic [3:0]  msk;
    int          nstb;
    int          nwait;
    logic [31:0] rd;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] dat;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[10];
  int   n_pass = 0;
  int   n_chk = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic vec_t mk(
    input logic [1:0] sp, input logic [3:0] slv, input logic we,
    input logic [13:0] adr, input logic [31:0] dat,
    input logic [3:0] aen, input logic [3:0] afo, input logic err,
    input int lat, input logic [3:0] msk, input int nstb,
    input int nwait, input logic [31:0] rd);
    vec_t v;
    v.sp = sp; v.slv = slv; v.we = we; v.adr = adr; v.dat = dat;
    v.aen = aen; v.afo = afo; v.err = err; v.lat = lat;
    v.msk = msk; v.nstb = nstb; v.nwait = nwait; v.rd = rd;
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input string nm);
    exp_t e;
    int n, ns, nw;
    bit done;
    logic [3:0] cm, sm;
    @(negedge clk);
    m_cyc = 1; m_stb = 1; m_we = v.we; m_adr = v.adr;
    m_dat_i = v.dat; m_speed = v.sp; m_slv = v.slv;
    ack_en = v.aen; ack_force = v.afo;
    e.err = v.err; e.dat = v.rd;
    sb.push_back(e);
    n = 0; ns = 0; nw = 0; done = 0; cm = '0; sm = '0;
    @(posedge clk);
    #1;
    m_adr = ~v.adr; m_dat_i = ~v.dat; m_slv = ~v.slv; m_speed = ~v.sp;
    while (!done && n < 200) begin
      @(negedge clk);
      if (s_stb != '0 && sm == '0) begin
        chk({nm, "_s_adr"}, 32'(s_adr), 32'(v.adr));
        chk({nm, "_s_dat_o"}, s_dat_o, v.dat);
        chk({nm, "_s_we"}, 32'(s_we), 32'(v.we));
      end
      cm = cm | s_cyc;
      sm = sm | s_stb;
      if (s_stb != '0) ns++;
      if (s_cyc != '0 && s_stb == '0) nw++;
      if (m_ack || m_err) done = 1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    if (done && sb.size() > 0) begin
      e = sb.pop_front();
      chk({nm, "_m_err"}, 32'(m_err), 32'(e.err));
      chk({nm, "_m_ack"}, 32'(m_ack), 32'(!e.err));
      chk({nm, "_m_dat_o"}, m_dat_o, e.dat);
    end else begin
      chk({nm, "_complete"}, 32'(n), 32'(v.lat));
      sb.delete();
    end
    m_cyc = 0; m_stb = 0; ack_en = '0; ack_force = '0;
    if (done) begin
      chk({nm, "_lat"}, 32'(n), 32'(v.lat));
      chk({nm, "_cyc_mask"}, 32'(cm), 32'(v.msk));
      chk({nm, "_stb_mask"}, 32'(sm), 32'(v.nstb > 0 ? v.msk : 4'b0));
      chk({nm, "_stb_cycles"}, 32'(ns), 32'(v.nstb));
      chk({nm, "_wait_cycles"}, 32'(nw), 32'(v.nwait));
      chk({nm, "_idle_busy"}, 32'({busy, s_cyc}), 32'(0));
      @(negedge clk);
      chk({nm, "_pulse"}, 32'({m_ack, m_err}), 32'(0));
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ack_err"}, 32'({m_ack, m_err}), 32'(0));
    chk({nm, "_m_dat_o"}, m_dat_o, 32'(0));
    chk({nm, "_s_cyc_stb"}, 32'({s_cyc, s_stb}), 32'(0));
    chk({nm, "_s_we_busy"}, 32'({s_we, busy}), 32'(0));
    chk({nm, "_s_adr"}, 32'(s_adr), 32'(0));
    chk({nm, "_s_dat_o"}, s_dat_o, 32'(0));
  endtask

  initial begin
    int spur;
    tbl[0] = mk(2'd3, 4'b0010, 0, 14'h0011, 32'h0, 4'hF, 4'h0,
                0, 2, 4'b0010, 1, 0, 32'h0000_00A5);
    tbl[1] = mk(2'd0, 4'b1000, 1, 14'h0222, 32'h1234_5678, 4'hF, 4'h0,
                0, 17, 4'b1000, 1, 15, 32'h0000_00A5);
    tbl[2] = mk(2'd2, 4'b1100, 0, 14'h0333, 32'h0, 4'hF, 4'h0,
                0, 5, 4'b0100, 1, 3, 32'h2222_2222);
    tbl[3] = mk(2'd1, 4'b0110, 0, 14'h0444, 32'h0, 4'hF, 4'h0,
                0, 9, 4'b0010, 1, 7, 32'h0000_00A5);
    tbl[4] = mk(2'd3, 4'b0000, 0, 14'h0555, 32'h0, 4'hF, 4'h0,
                0, 1, 4'b0000, 0, 0, 32'hFFFF_FFFF);
    tbl[5] = mk(2'd0, 4'b0000, 1, 14'h0666, 32'hDEAD_BEEF, 4'hF, 4'h0,
                0, 1, 4'b0000, 0, 0, 32'hFFFF_FFFF);
    tbl[6] = mk(2'd3, 4'b0001, 0, 14'h0777, 32'h0, 4'h0, 4'h0,
                1, 10, 4'b0001, 9, 0, 32'hFFFF_FFFF);
    tbl[7] = mk(2'd3, 4'b0100, 0, 14'h0888, 32'h0, 4'h0, 4'b1011,
                1, 10, 4'b0100, 9, 0, 32'hFFFF_FFFF);
    tbl[8] = mk(2'd0, 4'b0001, 0, 14'h0999, 32'h0, 4'hF, 4'h0,
                0, 17, 4'b0001, 1, 15, 32'h1111_0000);
    tbl[9] = mk(2'd3, 4'b0001, 1, 14'h0AAA, 32'h5555_AAAA, 4'hF, 4'h0,
                0, 2, 4'b0001, 1, 0, 32'h1111_0000);

    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i], $sformatf("v%0d", i));
    end

    // Abort in WAIT of a medium-speed read.
    @(negedge clk);
    m_cyc = 1; m_stb = 1; m_we = 0; m_speed = 2'd1;
    m_slv = 4'b0010; m_adr = 14'h0123; ack_en = 4'hF;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort_wait_cyc", 32'(s_cyc), 32'(4'b0010));
    chk("abort_wait_stb_busy", 32'({s_stb, busy}), 32'(1));
    m_cyc = 0; m_stb = 0;
    @(negedge clk);
    chk("abort_idle", 32'({s_cyc, s_stb, busy}), 32'(0));
    spur = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_ack || m_err) spur++;
    end
    chk("abort_no_done", 32'(spur), 32'(0));
    chk("abort_m_dat_o", m_dat_o, 32'h1111_0000);

    // Reset pulse during ACCESS of a write to a silent slave.
    @(negedge clk);
    m_cyc = 1; m_stb = 1; m_we = 1; m_speed = 2'd3;
    m_slv = 4'b0001; m_adr = 14'h0055; m_dat_i = 32'hCAFE_BABE;
    ack_en = 4'h0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_access_stb", 32'(s_stb), 32'(4'b0001));
    @(negedge clk);
    rst_n = 0;
    #1;
    chk_all_zero("rst_mid");
    m_cyc = 0; m_stb = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    spur = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m_ack || m_err || busy) spur++;
    end
    chk("rst_no_done", 32'(spur), 32'(0));
    run_txn(tbl[0], "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
